// File: rtl/fc_pkg.sv
// Shared definitions for the frame compositor: FSM states, colour modes,
// default VGA timing constants and the RGB332 expansion helper.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } fc_state_t;

    localparam logic [1:0] MODE_GRAY   = 2'd0;
    localparam logic [1:0] MODE_RGB332 = 2'd1;
    localparam logic [1:0] MODE_INV    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_H_OFFSET = 144;
    localparam int DEF_V_OFFSET = 36;

    // Replicates each RGB332 field's top bits so full-scale input maps to 8'hFF.
    function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/fc_delay_line.sv
// Fixed-depth shift register used to carry pixel sideband alongside RAM read latency.
module fc_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/frame_compositor.sv
// Pixel back-end: framebuffer init/sync sequencing, read-address generation,
// frame-latched crosshair overlay and per-mode colour expansion to the DAC.
module frame_compositor
    import fc_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          H_OFFSET = DEF_H_OFFSET,
    parameter int          V_OFFSET = DEF_V_OFFSET,
    parameter int          PIX_W    = 8,
    parameter int          ADDR_W   = 19,
    parameter int          RD_LAT   = 1,
    parameter int          CUR_ARM  = 5,
    parameter logic [23:0] CUR_RGB  = 24'hFF0000
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic              ativo,
    input  logic [10:0]       cursor_x,
    input  logic [10:0]       cursor_y,
    input  logic              cursor_en,
    input  logic [1:0]        mode,
    input  logic              reinit,
    output logic              init_req,
    input  logic              init_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              busy
);

    localparam logic [10:0]        H_OFF_U = 11'(H_OFFSET);
    localparam logic [10:0]        V_OFF_U = 11'(V_OFFSET);
    localparam logic [10:0]        V_LAST  = 11'(V_ACTIVE - 1);
    localparam logic signed [12:0] H_OFF_S = 13'(H_OFFSET);
    localparam logic signed [12:0] V_OFF_S = 13'(V_OFFSET);
    localparam logic signed [12:0] ARM_S   = 13'(CUR_ARM);

    fc_state_t         state, state_next;
    logic              sync_start, run_now, seen_blank;
    logic              ativo_q, line_end, frame_end;
    logic [10:0]       sx, sy, sy_q;
    logic [ADDR_W-1:0] line_base, addr_hold;
    logic [10:0]       cur_x_l, cur_y_l;
    logic              cur_en_l;
    logic signed [12:0] dx, dy, adx, ady;
    logic              hit, hit_d, valid_d;
    logic [7:0]        pix8;
    logic [23:0]       colour_next;

    assign sx        = x - H_OFF_U;
    assign sy        = y - V_OFF_U;
    assign line_end  = ativo_q && !ativo;
    assign frame_end = line_end && (sy_q == V_LAST);

    // Streaming starts on the first visible pixel itself, so SYNC->RUN is decoded combinationally.
    always_comb begin
        state_next = state;
        sync_start = 1'b0;
        run_now    = 1'b0;
        if (state == ST_SYNC && seen_blank && ativo && x == H_OFF_U && y == V_OFF_U)
            sync_start = 1'b1;
        case (state)
            ST_INIT: if (init_done) state_next = ST_SYNC;
            ST_SYNC: if (sync_start) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
        if (reinit) state_next = ST_INIT;
        run_now = (state == ST_RUN || sync_start) && !reinit;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            init_req   <= 1'b0;
            seen_blank <= 1'b0;
        end else begin
            state      <= state_next;
            init_req   <= (state_next == ST_INIT);
            seen_blank <= (state == ST_SYNC) && (seen_blank || !ativo);
        end
    end

    assign busy    = !run_now;
    assign rd_en   = ativo && run_now;
    assign rd_addr = rd_en ? line_base + ADDR_W'(sx) : addr_hold;

    // Line base replaces sy*H_ACTIVE: stepped at each line end, cleared after the last line.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ativo_q   <= 1'b0;
            sy_q      <= '0;
            addr_hold <= '0;
            line_base <= '0;
            cur_x_l   <= '0;
            cur_y_l   <= '0;
            cur_en_l  <= 1'b0;
        end else begin
            ativo_q   <= ativo;
            sy_q      <= sy;
            addr_hold <= rd_addr;
            if (state != ST_RUN)
                line_base <= '0;
            else if (line_end)
                line_base <= frame_end ? '0 : line_base + ADDR_W'(H_ACTIVE);
            if (frame_end) begin
                cur_x_l  <= cursor_x;
                cur_y_l  <= cursor_y;
                cur_en_l <= cursor_en;
            end
        end
    end

    // Signed distances keep the crosshair from wrapping around screen edges.
    assign dx  = $signed({2'b00, x}) - H_OFF_S - $signed({2'b00, cur_x_l});
    assign dy  = $signed({2'b00, y}) - V_OFF_S - $signed({2'b00, cur_y_l});
    assign adx = dx[12] ? -dx : dx;
    assign ady = dy[12] ? -dy : dy;
    assign hit = cur_en_l && (((dx == '0) && (ady <= ARM_S)) || ((dy == '0) && (adx <= ARM_S)));

    fc_delay_line #(.WIDTH(2), .DEPTH(RD_LAT)) u_sideband (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .din      ({rd_en, hit}),
        .dout     ({valid_d, hit_d})
    );

    assign pix8 = 8'(rd_data);

    always_comb begin
        colour_next = '0;
        if (valid_d && run_now) begin
            case (mode)
                MODE_GRAY:   colour_next = hit_d ? CUR_RGB : {3{pix8}};
                MODE_RGB332: colour_next = hit_d ? CUR_RGB : expand_rgb332(pix8);
                MODE_INV:    colour_next = hit_d ? {3{~pix8}} : {3{pix8}};
                MODE_RSVD:   colour_next = '0;
                default:     colour_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= colour_next;
        end
    end

endmodule

// File: tb/tb_frame_compositor.sv
// Self-checking bench for frame_compositor on a reduced 32x24 raster with an
// addr-as-data RAM model and a queue-based scoreboard of expected pixels.
module tb_frame_compositor;
    import fc_pkg::*;

    localparam int H_ACT  = 32;
    localparam int V_ACT  = 24;
    localparam int H_OFF  = 8;
    localparam int V_OFF  = 4;
    localparam int H_TOT  = 48;
    localparam int V_TOT  = 32;
    localparam int RD_LAT = 2;
    localparam int ARM    = 5;
    localparam int AW     = 10;
    localparam int LAT    = RD_LAT + 1;
    localparam logic [23:0] CUR = 24'hFF0000;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n;
    logic [10:0]   x, y, cursor_x, cursor_y;
    logic          ativo, cursor_en, reinit, init_done;
    logic [1:0]    mode;
    logic          init_req, rd_en, busy;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    VGA_R, VGA_G, VGA_B;

    int compared, mismatched;
    int hx, hy, frameNo, cyc, reinitCyc, initReqHigh;
    int mState, cx, cy, prevSy, lastAddr;
    bit seenBlank, cen, prevAtivo;
    logic [23:0] expQ[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    frame_compositor #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_OFFSET(H_OFF), .V_OFFSET(V_OFF),
        .PIX_W(8), .ADDR_W(AW), .RD_LAT(RD_LAT), .CUR_ARM(ARM), .CUR_RGB(CUR)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .x(x), .y(y), .ativo(ativo),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en), .mode(mode),
        .reinit(reinit), .init_req(init_req), .init_done(init_done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .busy(busy)
    );

    // RAM returns the low byte of the address RD_LAT cycles later.
    logic [7:0] ramPipe [RD_LAT];
    always_ff @(posedge CLOCK_50) begin
        ramPipe[0] <= rd_addr[7:0];
        for (int i = 1; i < RD_LAT; i++) ramPipe[i] <= ramPipe[i-1];
    end
    assign rd_data = ramPipe[RD_LAT-1];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h (cyc %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        logic [23:0] expv;
        @(posedge CLOCK_50);
        #1;
        if (expQ.size() == LAT) begin
            expv = expQ.pop_front();
            checkOutput("vga_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(expv));
        end
    endtask

    task automatic scheduleInputs();
        init_done = 1'b0;
        reinit    = 1'b0;
        if (cyc == 100 || cyc == reinitCyc + 20) init_done = 1'b1;
        if (hx == 0 && hy == 0) begin
            case (frameNo)
                0: begin mode = MODE_GRAY; cursor_x = 11'd16; cursor_y = 11'd12; cursor_en = 1'b1; end
                2: begin mode = MODE_INV; cursor_x = 11'd0; cursor_y = 11'd0; end
                3: mode = MODE_RGB332;
                4: begin mode = MODE_RSVD; cursor_en = 1'b0; end
                5: mode = MODE_GRAY;
                default: ;
            endcase
        end
        if (frameNo == 1 && hx == 0 && hy == V_OFF + 10) cursor_x = 11'd20;
        if (frameNo == 4 && hx == H_OFF + 5 && hy == V_OFF + 5) begin
            reinit    = 1'b1;
            reinitCyc = cyc;
        end
    endtask

    task automatic applyStimulus();
        int sx, sy;
        bit act, runNow, hitM;
        logic [7:0] d;
        logic [23:0] expv;
        x     = 11'(hx);
        y     = 11'(hy);
        act   = (hx >= H_OFF && hx < H_OFF + H_ACT && hy >= V_OFF && hy < V_OFF + V_ACT);
        ativo = act;
        sx    = hx - H_OFF;
        sy    = hy - V_OFF;
        runNow = (mState == 2 || (mState == 1 && seenBlank && hx == H_OFF && hy == V_OFF && act)) && !reinit;
        if (reinit) foreach (expQ[i]) expQ[i] = '0;
        expv = '0;
        if (act && runNow) begin
            d    = 8'(sy * H_ACT + sx);
            hitM = cen && ((sx == cx && iabs(sy - cy) <= ARM) || (sy == cy && iabs(sx - cx) <= ARM));
            case (mode)
                2'd0: expv = hitM ? CUR : {d, d, d};
                2'd1: expv = hitM ? CUR : {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3],
                                           d[1:0], d[1:0], d[1:0], d[1:0]};
                2'd2: expv = hitM ? {~d, ~d, ~d} : {d, d, d};
                default: expv = '0;
            endcase
            lastAddr = sy * H_ACT + sx;
        end
        expQ.push_back(expv);
        #1;
        checkOutput("busy", 32'(busy), 32'(!runNow));
        checkOutput("rd_en", 32'(rd_en), 32'(act && runNow));
        checkOutput("rd_addr", 32'(rd_addr), 32'(lastAddr));
        if (mState == 1 && runNow) checkOutput("busy_first_px", 32'(busy), 32'(0));
        if (frameNo == 1 && act && sx == 10 && sy == 2) checkOutput("addr_sx10_sy2", 32'(rd_addr), 32'(74));
        if (reinit) mState = 0;
        else begin
            case (mState)
                0: if (init_done) begin mState = 1; seenBlank = 1'b0; end
                1: if (runNow) mState = 2; else if (!act) seenBlank = 1'b1;
                default: ;
            endcase
        end
        if (prevAtivo && !act && prevSy == V_ACT - 1) begin
            cx  = int'(cursor_x);
            cy  = int'(cursor_y);
            cen = cursor_en;
        end
        prevAtivo = act;
        prevSy    = sy;
        hx++;
        if (hx == H_TOT) begin
            hx = 0;
            hy++;
            if (hy == V_TOT) begin
                hy = 0;
                frameNo++;
            end
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        hx = 0; hy = 0; frameNo = 0; cyc = 0; reinitCyc = -1000; initReqHigh = 0;
        mState = 0; seenBlank = 1'b0; cx = 0; cy = 0; cen = 1'b0; prevAtivo = 1'b0; prevSy = 0; lastAddr = 0;
        reset_n = 1'b0; x = '0; y = '0; ativo = 1'b0; cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
        mode = MODE_GRAY; reinit = 1'b0; init_done = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("rst_init_req", 32'(init_req), 32'(0));
        checkOutput("rst_rd_en", 32'(rd_en), 32'(0));
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'(0));
        checkOutput("rst_vga", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(1));
        reset_n = 1'b1;
        scheduleInputs();
        applyStimulus();
        while (!(frameNo == 5 && hy == V_OFF + 12 && hx == H_OFF + 6) && cyc < 20000) begin
            tick();
            if (init_req) initReqHigh++;
            if (cyc == 149) checkOutput("init_req_cycles", 32'(initReqHigh), 32'(100));
            if (cyc == reinitCyc) checkOutput("init_req_after_reinit", 32'(init_req), 32'(1));
            cyc++;
            scheduleInputs();
            applyStimulus();
        end
        if (cyc >= 20000) checkOutput("cycle_bound", 32'(cyc), 32'(0));
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_vga", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
        checkOutput("midrst_rd_en", 32'(rd_en), 32'(0));
        checkOutput("midrst_rd_addr", 32'(rd_addr), 32'(0));
        checkOutput("midrst_busy", 32'(busy), 32'(1));
        checkOutput("midrst_init_req", 32'(init_req), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
